// File: rtl/l2_flush_seq_pkg.sv
// Shared definitions for the L2 flush sequencer: coherence line-state
// encodings as returned by the tag/state array, and the sequencer FSM states.
package l2_flush_seq_pkg;

    localparam logic [1:0] LS_INVALID   = 2'd0;
    localparam logic [1:0] LS_SHARED    = 2'd1;
    localparam logic [1:0] LS_EXCLUSIVE = 2'd2;
    localparam logic [1:0] LS_MODIFIED  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_CHECK,
        ST_EVICT,
        ST_INVAL,
        ST_NEXT,
        ST_DONE
    } flush_state_e;

    // True when the line holds data that is newer than memory.
    function automatic logic is_dirty(input logic [1:0] st);
        return st == LS_MODIFIED;
    endfunction

endpackage

// File: rtl/l2_flush_ptr.sv
// Set/way walk pointers for the L2 flush sequencer. Way is the minor index,
// set the major one. End-of-walk is flagged by comparing against the last
// index rather than relying on counter carry-out.
module l2_flush_ptr
    import l2_flush_seq_pkg::*;
#(
    parameter int L2_SETS = 256,
    parameter int L2_WAYS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       incr,
    output logic [$clog2(L2_SETS)-1:0] set_idx,
    output logic [$clog2(L2_WAYS)-1:0] way_idx,
    output logic                       last_set,
    output logic                       last_way
);

    localparam int SET_W = $clog2(L2_SETS);
    localparam int WAY_W = $clog2(L2_WAYS);
    localparam logic [SET_W-1:0] SET_MAX = SET_W'(L2_SETS - 1);
    localparam logic [WAY_W-1:0] WAY_MAX = WAY_W'(L2_WAYS - 1);

    assign last_set = (set_idx == SET_MAX);
    assign last_way = (way_idx == WAY_MAX);

    // Advance way first; roll into the next set only after the last way.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_idx <= '0;
            way_idx <= '0;
        end else if (clear) begin
            set_idx <= '0;
            way_idx <= '0;
        end else if (incr) begin
            if (last_way) begin
                way_idx <= '0;
                if (!last_set) begin
                    set_idx <= set_idx + SET_W'(1);
                end
            end else begin
                way_idx <= way_idx + WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/l2_flush_seq.sv
// L2 flush sequencer: on a flush request, walks every set/way, reads the
// coherence state, pushes valid lines through the eviction path and then
// invalidates them. Throttles eviction issue against the request-slot pool.
// Build option: define L2_FLUSH_SKIP_CLEAN_EN to invalidate clean lines
// directly and only send MODIFIED lines through eviction.
module l2_flush_seq
    import l2_flush_seq_pkg::*;
#(
    parameter int L2_SETS = 256,
    parameter int L2_WAYS = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_valid,
    output logic                       flush_ready,
    output logic                       ongoing_flush,
    output logic                       flush_done,
    output logic                       rd_en,
    output logic [$clog2(L2_SETS)-1:0] rd_set,
    output logic [$clog2(L2_WAYS)-1:0] rd_way,
    input  logic [1:0]                 line_state,
    input  logic                       reqs_full,
    output logic                       evict_valid,
    input  logic                       evict_ready,
    output logic [$clog2(L2_SETS)-1:0] evict_set,
    output logic [$clog2(L2_WAYS)-1:0] evict_way,
    output logic                       evict_dirty,
    output logic                       wr_en
);

    localparam int SET_W = $clog2(L2_SETS);
    localparam int WAY_W = $clog2(L2_WAYS);

    flush_state_e     state;
    logic             first_check;
    logic [1:0]       state_q;
    logic [1:0]       cur_state;
    logic             evict_needed;
    logic             ptr_clear;
    logic             ptr_incr;
    logic             last_set;
    logic             last_way;
    logic [SET_W-1:0] set_idx;
    logic [WAY_W-1:0] way_idx;

    // line_state is only valid in the first CHECK cycle; stalled CHECK
    // cycles fall back to the latched copy.
    assign cur_state = first_check ? line_state : state_q;

`ifdef L2_FLUSH_SKIP_CLEAN_EN
    assign evict_needed = is_dirty(cur_state);
`else
    assign evict_needed = 1'b1;
`endif

    assign ptr_clear = (state == ST_IDLE) && flush_valid;
    assign ptr_incr  = (state == ST_NEXT);

    assign rd_set    = set_idx;
    assign rd_way    = way_idx;
    assign evict_set = set_idx;
    assign evict_way = way_idx;

    l2_flush_ptr #(
        .L2_SETS (L2_SETS),
        .L2_WAYS (L2_WAYS)
    ) u_ptr (
        .clk      (clk),
        .rst      (rst),
        .clear    (ptr_clear),
        .incr     (ptr_incr),
        .set_idx  (set_idx),
        .way_idx  (way_idx),
        .last_set (last_set),
        .last_way (last_way)
    );

    // Capture the returned line state on the first CHECK cycle only.
    always_ff @(posedge clk) begin
        if (state == ST_CHECK && first_check) begin
            state_q <= line_state;
        end
    end

    // Flush walk FSM; every output is registered on entry to its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            first_check   <= 1'b0;
            flush_ready   <= 1'b1;
            ongoing_flush <= 1'b0;
            flush_done    <= 1'b0;
            rd_en         <= 1'b0;
            evict_valid   <= 1'b0;
            evict_dirty   <= 1'b0;
            wr_en         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_valid) begin
                        state         <= ST_READ;
                        flush_ready   <= 1'b0;
                        ongoing_flush <= 1'b1;
                        rd_en         <= 1'b1;
                    end
                end
                ST_READ: begin
                    state       <= ST_CHECK;
                    rd_en       <= 1'b0;
                    first_check <= 1'b1;
                end
                ST_CHECK: begin
                    first_check <= 1'b0;
                    if (cur_state == LS_INVALID) begin
                        state <= ST_NEXT;
                    end else if (!evict_needed) begin
                        state <= ST_INVAL;
                        wr_en <= 1'b1;
                    end else if (!reqs_full) begin
                        state       <= ST_EVICT;
                        evict_valid <= 1'b1;
                        evict_dirty <= is_dirty(cur_state);
                    end
                end
                ST_EVICT: begin
                    if (evict_ready) begin
                        state       <= ST_INVAL;
                        evict_valid <= 1'b0;
                        evict_dirty <= 1'b0;
                        wr_en       <= 1'b1;
                    end
                end
                ST_INVAL: begin
                    state <= ST_NEXT;
                    wr_en <= 1'b0;
                end
                ST_NEXT: begin
                    if (last_way && last_set) begin
                        state      <= ST_DONE;
                        flush_done <= 1'b1;
                    end else begin
                        state <= ST_READ;
                        rd_en <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    flush_done    <= 1'b0;
                    ongoing_flush <= 1'b0;
                    flush_ready   <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_l2_flush_seq.sv
// Testbench for l2_flush_seq (4 sets x 2 ways). A behavioural tag/state
// memory answers reads; a per-line cost model predicts the cycle of every
// read, eviction, handshake, write and the done pulse.
module tb_l2_flush_seq;

    localparam int S = 4;
    localparam int W = 2;
`ifdef L2_FLUSH_SKIP_CLEAN_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_valid;
    logic       flush_ready;
    logic       ongoing_flush;
    logic       flush_done;
    logic       rd_en;
    logic [1:0] rd_set;
    logic       rd_way;
    logic [1:0] line_state;
    logic       reqs_full;
    logic       evict_valid;
    logic       evict_ready;
    logic [1:0] evict_set;
    logic       evict_way;
    logic       evict_dirty;
    logic       wr_en;

    always #5 clk = ~clk;

    l2_flush_seq #(.L2_SETS(S), .L2_WAYS(W)) dut (
        .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_ready(flush_ready),
        .ongoing_flush(ongoing_flush), .flush_done(flush_done), .rd_en(rd_en),
        .rd_set(rd_set), .rd_way(rd_way), .line_state(line_state), .reqs_full(reqs_full),
        .evict_valid(evict_valid), .evict_ready(evict_ready), .evict_set(evict_set),
        .evict_way(evict_way), .evict_dirty(evict_dirty), .wr_en(wr_en)
    );

    typedef struct {int cyc; int s; int w; int d; int len;} ev_t;

    ev_t rd_q[$];
    ev_t evs_q[$];
    ev_t wr_q[$];
    int  hs_q[$];
    int  mem  [S][W];
    int  snap [S][W];
    bit  rf_log[int];
    bit  er_log[int];

    int  cyc = 0;
    bit  recording = 1'b0;
    int  ong_cnt, done_cnt;
    bit  prev_rd = 1'b0;
    int  prev_s, prev_w;
    int  rf_mode = 0;
    int  rf_cnt = 0;
    int  rf_ts, rf_tw;
    int  er_delay = -1;
    int  ev_k = 0;
    ev_t ev_cur;
    int  pass_cnt = 0;
    int  fail_cnt = 0;
    int  total = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: observe outputs just after the edge, then drive responses.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (prev_rd) line_state = 2'(mem[prev_s][prev_w]);
        else         line_state = 2'($urandom_range(0, 3));
        if (rf_mode == 2 && prev_rd && prev_s == rf_ts && prev_w == rf_tw) rf_cnt = 5;
        case (rf_mode)
            1: reqs_full = 1'($urandom_range(0, 1));
            2: begin
                reqs_full = (rf_cnt > 0);
                if (rf_cnt > 0) rf_cnt--;
            end
            default: reqs_full = 1'b0;
        endcase
        rf_log[cyc] = reqs_full;
        prev_rd = rd_en;
        prev_s  = int'(rd_set);
        prev_w  = int'(rd_way);
        if (recording && rd_en) rd_q.push_back(ev_t'{cyc, int'(rd_set), int'(rd_way), 0, 0});
        if (wr_en) begin
            mem[rd_set][rd_way] = 0;
            if (recording) wr_q.push_back(ev_t'{cyc, int'(rd_set), int'(rd_way), 0, 0});
        end
        if (recording && ongoing_flush) ong_cnt++;
        if (recording && flush_done) done_cnt++;
        if (evict_valid) begin
            if (ev_k == 0) ev_cur = ev_t'{cyc, int'(evict_set), int'(evict_way), int'(evict_dirty), 0};
            else check("evict_hold_stable", evict_set * 4 + evict_way * 2 + evict_dirty,
                       ev_cur.s * 4 + ev_cur.w * 2 + ev_cur.d);
            ev_k++;
            evict_ready = (er_delay < 0) ? 1'($urandom_range(0, 1)) : (ev_k > er_delay);
            if (evict_ready) begin
                ev_cur.len = ev_k;
                if (recording) begin
                    evs_q.push_back(ev_cur);
                    hs_q.push_back(cyc);
                end
                ev_k = 0;
            end
        end else begin
            ev_k = 0;
            evict_ready = 1'($urandom_range(0, 1));
        end
        er_log[cyc] = evict_ready;
    endtask

    // Runs one flush and compares every event against the per-line cost model.
    task automatic run_flush(input bit hold, input bit pre, output int a, output int done);
        int t, ri, ei, wi, st, c, e, h;
        bit ev_need;
        a = -1;
        done = -1;
        if (pre) a = cyc;
        else begin
            for (int i = 0; i < 20 && a < 0; i++) begin
                tick();
                flush_valid = 1'b1;
                if (flush_ready) a = cyc;
            end
        end
        check("flush_accepted", a >= 0, 1);
        snap = mem;
        rd_q.delete(); evs_q.delete(); wr_q.delete(); hs_q.delete();
        ong_cnt = 0;
        done_cnt = 0;
        recording = 1'b1;
        for (int i = 0; i < 3000 && done < 0; i++) begin
            tick();
            if (!hold) flush_valid = 1'($urandom_range(0, 1));
            if (flush_done) begin
                done = cyc;
                if (!hold) flush_valid = 1'b0;
            end
        end
        recording = 1'b0;
        check("done_within_budget", done >= 0, 1);
        t = a + 1; ri = 0; ei = 0; wi = 0;
        for (int s = 0; s < S; s++) begin
            for (int w = 0; w < W; w++) begin
                if (ri < rd_q.size()) begin
                    check("rd_cycle", rd_q[ri].cyc, t);
                    check("rd_addr", rd_q[ri].s * W + rd_q[ri].w, s * W + w);
                end else check("rd_missing", 0, 1);
                ri++;
                st = snap[s][w];
                ev_need = SKIP ? (st == 3) : (st != 0);
                if (st == 0) begin
                    t += 3;
                end else if (!ev_need) begin
                    if (wi < wr_q.size()) begin
                        check("wr_cycle_clean", wr_q[wi].cyc, t + 2);
                        check("wr_addr_clean", wr_q[wi].s * W + wr_q[wi].w, s * W + w);
                    end else check("wr_missing", 0, 1);
                    wi++;
                    t += 4;
                end else begin
                    c = t + 1;
                    while (c < cyc && rf_log.exists(c) && rf_log[c]) c++;
                    e = c + 1;
                    h = e;
                    while (h < cyc && !(er_log.exists(h) && er_log[h])) h++;
                    if (ei < evs_q.size()) begin
                        check("evict_start_cycle", evs_q[ei].cyc, e);
                        check("evict_addr", evs_q[ei].s * W + evs_q[ei].w, s * W + w);
                        check("evict_dirty", evs_q[ei].d, st == 3);
                        check("evict_handshake_cycle", hs_q[ei], h);
                    end else check("evict_missing", 0, 1);
                    ei++;
                    if (wi < wr_q.size()) begin
                        check("wr_cycle", wr_q[wi].cyc, h + 1);
                        check("wr_addr", wr_q[wi].s * W + wr_q[wi].w, s * W + w);
                    end else check("wr_missing", 0, 1);
                    wi++;
                    t = h + 3;
                end
            end
        end
        check("done_cycle", done, t);
        check("read_count", rd_q.size(), S * W);
        check("evict_count", evs_q.size(), ei);
        check("write_count", wr_q.size(), wi);
        check("done_pulse_count", done_cnt, 1);
        check("ongoing_cycles", ong_cnt, done - a);
    endtask

    task automatic fill_random();
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++)
                mem[s][w] = $urandom_range(0, 3);
    endtask

    task automatic fill_invalid();
        for (int s = 0; s < S; s++)
            for (int w = 0; w < W; w++)
                mem[s][w] = 0;
    endtask

    initial begin
        int a, d, found, seen_done;
        rst = 1'b1;
        flush_valid = 1'b0;
        line_state = 2'd0;
        reqs_full = 1'b0;
        evict_ready = 1'b0;
        fill_invalid();
        repeat (2) @(posedge clk);
        #1;
        check("rst_flush_ready", flush_ready, 1);
        check("rst_ongoing", ongoing_flush, 0);
        check("rst_done", flush_done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_evict_valid", evict_valid, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_ptr", rd_set * W + rd_way, 0);
        rst = 1'b0;
        tick();
        tick();

        // All lines invalid: plain walk, 3 cycles per line.
        rf_mode = 0; er_delay = -1;
        fill_invalid();
        run_flush(1'b0, 1'b0, a, d);
        check("all_invalid_latency", d - (a + 1), 24);
        check("all_invalid_no_evict", evs_q.size(), 0);

        // One MODIFIED line, evict_ready held off for 3 cycles.
        fill_invalid();
        mem[2][1] = 3;
        er_delay = 3;
        run_flush(1'b0, 1'b0, a, d);
        check("mod_evict_count", evs_q.size(), 1);
        if (evs_q.size() == 1) begin
            check("mod_evict_len", evs_q[0].len, 4);
            check("mod_evict_target", evs_q[0].s * 8 + evs_q[0].w * 2 + evs_q[0].d, 2 * 8 + 1 * 2 + 1);
        end
        check("mod_write_count", wr_q.size(), 1);
        if (wr_q.size() == 1) check("mod_write_addr", wr_q[0].s * W + wr_q[0].w, 2 * W + 1);

        // One SHARED line with the request pool full for 5 CHECK cycles.
        fill_invalid();
        mem[1][0] = 1;
        rf_mode = 2; rf_ts = 1; rf_tw = 0;
        er_delay = 0;
        run_flush(1'b0, 1'b0, a, d);
        if (SKIP) begin
            check("shared_skip_no_evict", evs_q.size(), 0);
            if (wr_q.size() == 1 && rd_q.size() > 2) check("shared_skip_wr_delay", wr_q[0].cyc - rd_q[2].cyc, 2);
            else check("shared_skip_wr_present", 0, 1);
        end else begin
            check("shared_evict_count", evs_q.size(), 1);
            if (evs_q.size() == 1 && rd_q.size() > 2) begin
                check("shared_evict_delay", evs_q[0].cyc - rd_q[2].cyc, 7);
                check("shared_evict_dirty", evs_q[0].d, 0);
            end
        end

        // Randomized contents, pool pressure and eviction back-pressure.
        rf_mode = 1; er_delay = -1;
        for (int k = 0; k < 3; k++) begin
            fill_random();
            run_flush(1'b0, 1'b0, a, d);
        end
        tick();
        tick();
        check("idle_after_random_ongoing", ongoing_flush, 0);
        check("idle_after_random_rd_en", rd_en, 0);
        check("idle_after_random_ready", flush_ready, 1);

        // flush_valid held across completion: back-to-back flushes.
        fill_random();
        run_flush(1'b1, 1'b0, a, d);
        tick();
        check("b2b_gap_ongoing", ongoing_flush, 0);
        check("b2b_gap_ready", flush_ready, 1);
        fill_random();
        run_flush(1'b0, 1'b1, a, d);

        // Reset while an eviction at set 1 is pending.
        fill_invalid();
        mem[1][0] = 3;
        rf_mode = 0; er_delay = 1000;
        tick();
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (evict_valid && rd_set == 2'd1) found = 1;
            else tick();
        end
        check("abort_reached_evict", found, 1);
        rst = 1'b1;
        tick();
        check("abort_ready", flush_ready, 1);
        check("abort_evict_valid", evict_valid, 0);
        check("abort_ptr", rd_set * W + rd_way, 0);
        check("abort_ongoing", ongoing_flush, 0);
        rst = 1'b0;
        seen_done = flush_done;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (flush_done) seen_done = 1;
        end
        check("abort_no_done", seen_done, 0);
        check("abort_idle_ready", flush_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
